// File: rtl/dt_vote_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : dt_vote_accum_if
// Brief    : Sample-in / result-out bundle of the vote accumulator.
//            Optional out_reject exists only when DT_VOTE_MIN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface dt_vote_accum_if #(
    parameter int CLASS_W = 3,
    parameter int CNT_W   = 5
) ();
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] in_class;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic [CNT_W-1:0]   out_count;
    logic [CNT_W-1:0]   out_total;
`ifdef DT_VOTE_MIN_EN
    logic               out_reject;

    modport master (
        output in_valid, in_class, flush, out_ready,
        input  in_ready, out_valid, out_class, out_count, out_total, out_reject
    );
    modport slave (
        input  in_valid, in_class, flush, out_ready,
        output in_ready, out_valid, out_class, out_count, out_total, out_reject
    );
`else
    modport master (
        output in_valid, in_class, flush, out_ready,
        input  in_ready, out_valid, out_class, out_count, out_total
    );
    modport slave (
        input  in_valid, in_class, flush, out_ready,
        output in_ready, out_valid, out_class, out_count, out_total
    );
`endif
endinterface
`default_nettype wire

// File: rtl/dt_vote_accum.sv
`default_nettype none
// ============================================================================
// Module   : dt_vote_accum
// Brief    : Windowed per-class vote counter with sequential argmax scan.
//            Optional minimum-vote reject flag: define DT_VOTE_MIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dt_vote_accum #(
    parameter int CLASS_W   = 3,
    parameter int WINDOW    = 16,
    parameter int CNT_W     = 5
`ifdef DT_VOTE_MIN_EN
    ,
    parameter int MIN_VOTES = 9
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dt_vote_accum_if.slave     bus
);
    localparam int c_num_classes = 2 ** CLASS_W;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [CNT_W-1:0]   r_votes [c_num_classes];
    logic [CNT_W-1:0]   r_samples;
    logic [CLASS_W-1:0] r_idx;
    logic [CLASS_W-1:0] r_best_cls;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [CLASS_W-1:0] r_out_class;
    logic [CNT_W-1:0]   r_out_count;
    logic [CNT_W-1:0]   r_out_total;

    logic               w_accept;
    logic               w_close;
    logic               w_scan_done;
    logic               w_handshake;
    logic [CNT_W-1:0]   w_samples_inc;
    logic [CNT_W-1:0]   w_cand;
    logic               w_better;
    logic [CLASS_W-1:0] w_best_cls_nxt;
    logic [CNT_W-1:0]   w_best_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_close       = 1'b0;
        w_scan_done   = 1'b0;
        w_handshake   = 1'b0;
        w_samples_inc = r_samples + CNT_W'(1);
        case (r_state)
            ACCUM: begin
                w_accept = bus.in_valid;
                // A flush in the same cycle as a sample still counts that sample.
                if ((w_accept && (w_samples_inc == CNT_W'(WINDOW))) ||
                    (bus.flush && (w_accept || (r_samples != '0)))) begin
                    w_close      = 1'b1;
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                if (r_idx == CLASS_W'(c_num_classes - 1)) begin
                    w_scan_done  = 1'b1;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_handshake  = 1'b1;
                    w_state_next = ACCUM;
                end
            end
            default: w_state_next = ACCUM;
        endcase
    end

    // Strictly-greater update keeps the lowest class index on ties.
    assign w_cand         = r_votes[r_idx];
    assign w_better       = (w_cand > r_best_cnt);
    assign w_best_cnt_nxt = w_better ? w_cand : r_best_cnt;
    assign w_best_cls_nxt = w_better ? r_idx  : r_best_cls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_classes; i++) begin
                r_votes[i] <= '0;
            end
            r_samples   <= '0;
            r_idx       <= '0;
            r_best_cls  <= '0;
            r_best_cnt  <= '0;
            r_out_class <= '0;
            r_out_count <= '0;
            r_out_total <= '0;
        end else begin
            if (w_accept) begin
                r_votes[bus.in_class] <= r_votes[bus.in_class] + CNT_W'(1);
                r_samples             <= w_samples_inc;
            end
            if (w_close) begin
                r_idx      <= '0;
                r_best_cls <= '0;
                r_best_cnt <= '0;
            end
            if (r_state == SCAN) begin
                r_idx      <= r_idx + CLASS_W'(1);
                r_best_cls <= w_best_cls_nxt;
                r_best_cnt <= w_best_cnt_nxt;
            end
            if (w_scan_done) begin
                r_out_class <= w_best_cls_nxt;
                r_out_count <= w_best_cnt_nxt;
                r_out_total <= r_samples;
            end
            if (w_handshake) begin
                for (int i = 0; i < c_num_classes; i++) begin
                    r_votes[i] <= '0;
                end
                r_samples <= '0;
            end
        end
    end

`ifdef DT_VOTE_MIN_EN
    logic r_out_reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_reject <= 1'b0;
        end else if (w_scan_done) begin
            r_out_reject <= (w_best_cnt_nxt < CNT_W'(MIN_VOTES));
        end
    end

    assign bus.out_reject = r_out_reject;
`endif

    assign bus.in_ready  = rst_n && (r_state == ACCUM);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_class = r_out_class;
    assign bus.out_count = r_out_count;
    assign bus.out_total = r_out_total;

endmodule
`default_nettype wire

// File: tb/tb_dt_vote_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_dt_vote_accum
// Brief    : Table-driven vote-window vectors plus hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dt_vote_accum;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    dt_vote_accum_if #(.CLASS_W(3), .CNT_W(5)) bus ();

    dt_vote_accum #(.CLASS_W(3), .WINDOW(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] cls_a;
        int         n_a;
        logic [2:0] cls_b;
        int         n_b;
        bit         fl;
        int         e_cls;
        int         e_cnt;
        int         e_tot;
        int         e_rej;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_samples(input logic [2:0] cls_a, input int n_a,
                                input logic [2:0] cls_b, input int n_b, input bit fl);
        int n;
        n = n_a + n_b;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_class = (i < n_a) ? cls_a : cls_b;
            bus.flush    = fl && (i == n - 1);
            @(posedge clk);
        end
    endtask

    // Returns the number of negedges after the last accept until out_valid (0 = never).
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.flush    = 1'b0;
            if (bus.out_valid) lat = c;
        end
    endtask

    task automatic run_window(input vec_t v);
        int lat;
        send_samples(v.cls_a, v.n_a, v.cls_b, v.n_b, v.fl);
        wait_valid(lat);
        check("latency", lat, 9);
        check("out_class", int'(bus.out_class), v.e_cls);
        check("out_count", int'(bus.out_count), v.e_cnt);
        check("out_total", int'(bus.out_total), v.e_tot);
`ifdef DT_VOTE_MIN_EN
        check("out_reject", int'(bus.out_reject), v.e_rej);
`endif
        @(negedge clk);
        check("in_ready_after_hs", int'(bus.in_ready), 1);
        check("out_valid_after_hs", int'(bus.out_valid), 0);
    endtask

    initial begin
        int  lat;
        bit  bad;
        tests = 0;
        fails = 0;

        vecs[0] = '{3'd3, 10, 3'd5, 6,  1'b0, 3, 10, 16, 0};
        vecs[1] = '{3'd6, 8,  3'd2, 8,  1'b0, 2, 8,  16, 1};
        vecs[2] = '{3'd4, 3,  3'd0, 0,  1'b1, 4, 3,  3,  1};
        vecs[3] = '{3'd1, 5,  3'd0, 5,  1'b1, 0, 5,  10, 1};
        vecs[4] = '{3'd7, 1,  3'd2, 15, 1'b0, 2, 15, 16, 0};
        vecs[5] = '{3'd5, 1,  3'd0, 0,  1'b1, 5, 1,  1,  1};
        vecs[6] = '{3'd0, 8,  3'd1, 8,  1'b0, 0, 8,  16, 1};
        vecs[7] = '{3'd0, 9,  3'd0, 0,  1'b1, 0, 9,  9,  0};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_class = '0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_class", int'(bus.out_class), 0);
        check("rst_out_count", int'(bus.out_count), 0);
        check("rst_out_total", int'(bus.out_total), 0);
`ifdef DT_VOTE_MIN_EN
        check("rst_out_reject", int'(bus.out_reject), 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);

        for (int i = 0; i < 8; i++) begin
            run_window(vecs[i]);
        end

        // Flush with an empty window must not start a scan.
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) bad = 1'b1;
        end
        check("empty_flush_ignored", int'(bad), 0);

        // Backpressure: result held for 20 cycles while class-1 samples are offered.
        bus.out_ready = 1'b0;
        send_samples(3'd3, 16, 3'd0, 0, 1'b0);
        wait_valid(lat);
        check("bp_latency", lat, 9);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = 1'b1;
            bus.in_class = 3'd1;
            bus.flush    = 1'b1;
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.out_class != 3'd3 ||
                bus.out_count != 5'd16 || bus.out_total != 5'd16) bad = 1'b1;
        end
        check("bp_hold_stable", int'(bad), 0);
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_released_in_ready", int'(bus.in_ready), 1);
        check("bp_kept_class", int'(bus.out_class), 3);
        run_window('{3'd1, 12, 3'd4, 4, 1'b0, 1, 12, 16, 0});

        // Asynchronous reset in the middle of a scan drops the result.
        send_samples(3'd2, 16, 3'd0, 0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midscan_rst_in_ready", int'(bus.in_ready), 0);
        check("midscan_rst_out_valid", int'(bus.out_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid || !bus.in_ready) bad = 1'b1;
        end
        check("midscan_no_valid", int'(bad), 0);
        check("midscan_out_count", int'(bus.out_count), 0);
        run_window('{3'd7, 16, 3'd0, 0, 1'b0, 7, 16, 16, 0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
